shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller for the 4-bit ALU shift/rotate datapath.
- Accepts one operation with a 4-bit shift amount (0..15). The per-cycle shift unit handles only 0..3 positions, so the block drives it iteratively.
- Supports four operations: logical shift left, logical shift right, rotate left, rotate right.
- Sits between the ALU opcode decode and the result mux, with a start/ready/done handshake.

Parameters:
- DATA_W, 4, operand/result width.
- AMT_W, 4, shift-amount width.
- STEP_MAX, 3, maximum positions shifted per cycle (fits a 2-bit step field).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- op  input  2  00=SHL, 01=SHR, 10=ROL, 11=ROR; sampled at accept.
- operand  input  DATA_W  data to shift; sampled at accept.
- amount  input  AMT_W  total shift count; sampled at accept.
- abort  input  1  cancel the in-flight operation.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  DATA_W  final value; valid at done, held until the next accept.
- carry  output  1  last bit shifted/rotated out (see Optional Feature).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE; ready=1; busy=0; done=0; result=0; carry=0; internal data/remaining/op registers = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 -> latch op, operand, amount; remaining=amount.
  - Then go to RUN if amount!=0, else DONE.
- RUN, each cycle:
  - step = min(remaining, STEP_MAX).
  - data <= shift_step(data, op, step); remaining <= remaining - step.
  - When remaining-step==0, next state is DONE.
- DONE: done=1 and result=data for exactly one cycle, then IDLE. result keeps its value after leaving DONE.
- Latency: accept at cycle T -> done at T+1+ceil(amount/3).
  - amount=0: done at T+1 with result=operand.
  - amount=15: done at T+6.
- Arithmetic:
  - SHL/SHR zero-fill, so any amount >= DATA_W yields 0.
  - ROL/ROR wrap naturally by iteration, equivalent to amount mod 4.
- start while busy or in DONE: ignored, with no queuing.
- abort:
  - In RUN -> next state IDLE; no done pulse; result and carry unchanged from the previous operation.
  - In DONE -> ignored; the done pulse still occurs.
  - abort together with start in IDLE -> abort wins, nothing accepted.
- rst mid-operation: immediate return to reset values, with no done pulse.
- Inputs op, operand and amount are don't-care outside the accept cycle.

Optional Feature:
- Macro: SHIFT_SEQUENCER_CARRY_EN.
- Defined:
  - carry tracks the last bit leaving the word in the final step: MSB side for SHL/ROL, LSB side for SHR/ROR.
  - carry updates with result at DONE.
  - amount=0 -> carry=0.
- Undefined: carry tied to 0; no carry logic synthesized. The port is always present.

Decomposition:
- Shared package: op codes (OP_SHL, OP_SHR, OP_ROL, OP_ROR), state encoding (ST_IDLE, ST_RUN, ST_DONE), and the STEP_MAX constant.
- Sub-module shift_step4:
  - Combinational inputs: data[DATA_W-1:0], op[1:0], step[1:0].
  - Outputs: shifted data and the shifted-out bit.
  - Instantiated once in the sequencer.

Test Plan:
- ROL, operand=4'b1011, amount=5, accept at T -> busy T+1..T+2, done at T+3, result=4'b0111; carry=1 with the macro, 0 without.
- SHL, operand=4'b1011, amount=7 -> done at T+4, result=4'b0000; second start issued at T+2 is ignored (ready=0).
- SHR, operand=4'b1001, amount=1 -> done at T+2, result=4'b0100, carry=1 (with macro).
- ROR, operand=4'b0001, amount=0 -> done at T+1, result=4'b0001, carry=0; ready back to 1 at T+2.
- SHL, amount=15, abort asserted at T+2 -> no done pulse, IDLE at T+3, result equal to the prior value. Then start+abort in the same IDLE cycle -> not accepted.
- rst asserted at T+2 of a 6-cycle operation -> next cycle ready=1, busy=0, done=0, result=0, carry=0.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift/rotate sequencer: op codes, FSM states,
// datapath widths and the per-cycle step limit of the shift unit.
package shift_sequencer_pkg;

   localparam int DATA_W   = 4;
   localparam int AMT_W    = 4;
   localparam int STEP_MAX = 3;
   localparam int STEP_W   = 2;

   typedef enum logic [1:0] {
      OP_SHL = 2'b00,
      OP_SHR = 2'b01,
      OP_ROL = 2'b10,
      OP_ROR = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Largest chunk the shift unit can take out of what is still left to shift.
   function automatic logic [STEP_W-1:0] clamp_step(input logic [AMT_W-1:0] remaining);
      if (remaining >= AMT_W'(STEP_MAX))
         return STEP_W'(STEP_MAX);
      else
         return remaining[STEP_W-1:0];
   endfunction

endpackage

// File: rtl/shift_sequencer_shift_step4.sv
// Single-cycle shift/rotate unit for 0..3 positions; also reports the last
// bit pushed out of the word (MSB side for left ops, LSB side for right ops).
module shift_step4
   import shift_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        op,
   input  logic [STEP_W-1:0] step,
   output logic [DATA_W-1:0] shifted,
   output logic              out_bit
);

   logic [2*DATA_W-1:0] left_wide;
   logic [2*DATA_W-1:0] right_wide;

   // The spill half of a double-width shift holds the bits leaving the word;
   // OR-ing it back gives the rotate, and its edge bit is the last one out.
   assign left_wide  = {{DATA_W{1'b0}}, data} << step;
   assign right_wide = {data, {DATA_W{1'b0}}} >> step;

   always_comb begin
      shifted = data;
      out_bit = 1'b0;
      case (op)
         OP_SHL: begin
            shifted = left_wide[DATA_W-1:0];
            out_bit = left_wide[DATA_W];
         end
         OP_SHR: begin
            shifted = right_wide[2*DATA_W-1:DATA_W];
            out_bit = right_wide[DATA_W-1];
         end
         OP_ROL: begin
            shifted = left_wide[DATA_W-1:0] | left_wide[2*DATA_W-1:DATA_W];
            out_bit = left_wide[DATA_W];
         end
         default: begin
            shifted = right_wide[2*DATA_W-1:DATA_W] | right_wide[DATA_W-1:0];
            out_bit = right_wide[DATA_W-1];
         end
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller driving a 0..3 position shift unit.
// Define SHIFT_SEQUENCER_CARRY_EN to report the last bit shifted out on carry.
module shift_sequencer
   import shift_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] operand,
   input  logic [AMT_W-1:0]  amount,
   input  logic              abort,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   state_t              state;
   state_t              state_next;
   logic [1:0]          op_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   result_q;
   logic [AMT_W-1:0]    remaining;
   logic [STEP_W-1:0]   step;
   logic [DATA_W-1:0]   step_data;
   logic                accept;
   logic                last_step;
`ifdef SHIFT_SEQUENCER_CARRY_EN
   logic                step_out;
   logic                last_out;
   logic                carry_q;
`else
   logic                unused_step_out;
`endif

   assign accept    = start && !abort;
   assign step      = clamp_step(remaining);
   assign last_step = (remaining == AMT_W'(step));

   shift_step4 u_step (
      .data    (data_q),
      .op      (op_q),
      .step    (step),
      .shifted (step_data),
`ifdef SHIFT_SEQUENCER_CARRY_EN
      .out_bit (step_out)
`else
      .out_bit (unused_step_out)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Abort only cancels work still in RUN; a finished result always gets its done pulse.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_next = (amount != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            if (abort)
               state_next = ST_IDLE;
            else if (last_step)
               state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         data_q    <= '0;
         remaining <= '0;
         result_q  <= '0;
`ifdef SHIFT_SEQUENCER_CARRY_EN
         last_out  <= 1'b0;
         carry_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q      <= op;
                  data_q    <= operand;
                  remaining <= amount;
`ifdef SHIFT_SEQUENCER_CARRY_EN
                  last_out  <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               data_q    <= step_data;
               remaining <= remaining - AMT_W'(step);
`ifdef SHIFT_SEQUENCER_CARRY_EN
               last_out  <= step_out;
`endif
            end
            ST_DONE: begin
               result_q <= data_q;
`ifdef SHIFT_SEQUENCER_CARRY_EN
               carry_q  <= last_out;
`endif
            end
            default: begin
            end
         endcase
      end
   end

   // In DONE the fresh value is shown directly; afterwards the held copy takes over.
   always_comb begin
      ready  = (state == ST_IDLE);
      busy   = (state == ST_RUN);
      done   = (state == ST_DONE);
      result = (state == ST_DONE) ? data_q : result_q;
`ifdef SHIFT_SEQUENCER_CARRY_EN
      carry  = (state == ST_DONE) ? last_out : carry_q;
`else
      carry  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus random
// operations compared against an arithmetic model of shifts and latency.
module tb_shift_sequencer;
   import shift_sequencer_pkg::*;

`ifdef SHIFT_SEQUENCER_CARRY_EN
   localparam bit CARRY_ON = 1'b1;
`else
   localparam bit CARRY_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [1:0] op;
   logic [3:0] operand;
   logic [3:0] amount;
   logic       ready;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic       carry;

   int         errors = 0;
   int         checks = 0;
   logic [3:0] prev_result;
   logic       prev_carry;

   always #5 clk = ~clk;

   shift_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .operand (operand),
      .amount  (amount),
      .abort   (abort),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .carry   (carry)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Whole-amount shift computed at once, no stepping.
   function automatic logic [3:0] ref_result(input logic [1:0] o, input logic [3:0] d, input logic [3:0] a);
      int v = int'(d);
      int n = int'(a);
      int r = n % 4;
      int res;
      case (o)
         2'b00:   res = (n >= 4) ? 0 : (v << n);
         2'b01:   res = v >> n;
         2'b10:   res = (v << r) | (v >> (4 - r));
         default: res = (v >> r) | (v << (4 - r));
      endcase
      return 4'(res & 15);
   endfunction

   // The n-th single-position move pushes out a known original bit (or a fill zero).
   function automatic logic ref_carry(input logic [1:0] o, input logic [3:0] d, input logic [3:0] a);
      int v = int'(d);
      int n = int'(a);
      int res;
      if (n == 0) return 1'b0;
      case (o)
         2'b00:   res = (n <= 4) ? ((v >> (4 - n)) & 1) : 0;
         2'b01:   res = (n <= 4) ? ((v >> (n - 1)) & 1) : 0;
         2'b10:   res = (v >> ((4 - (n % 4)) % 4)) & 1;
         default: res = (v >> ((n - 1) % 4)) & 1;
      endcase
      return res[0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [1:0] o, input logic [3:0] d, input logic [3:0] a);
      op      = o;
      operand = d;
      amount  = a;
      abort   = 1'b0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      op      = 2'($urandom);
      operand = 4'($urandom);
      amount  = 4'($urandom);
   endtask

   // Walks the cycles after acceptance, optionally issuing a stray start or an abort.
   task automatic check_output(input logic [1:0] o, input logic [3:0] d, input logic [3:0] a,
                               input int abort_cycle, input int start_cycle, input string tag);
      int   lat     = 1 + (int'(a) + 2) / 3;
      bit   aborted = (abort_cycle >= 1) && (abort_cycle < lat);
      int   run_end = aborted ? abort_cycle + 1 : lat;
      int   last    = aborted ? abort_cycle + 1 : lat + 1;
      logic [3:0] exp_res = ref_result(o, d, a);
      logic       exp_car = CARRY_ON ? ref_carry(o, d, a) : 1'b0;
      for (int c = 1; c <= last; c++) begin
         if (!aborted && c == lat) begin
            check({tag, "/hs_done"}, 32'({ready, busy, done}), 32'(3'b001));
            check({tag, "/result"}, 32'(result), 32'(exp_res));
            check({tag, "/carry"}, 32'(carry), 32'(exp_car));
            prev_result = exp_res;
            prev_carry  = exp_car;
         end else if (c < run_end) begin
            check({tag, "/hs_run"}, 32'({ready, busy, done}), 32'(3'b010));
         end else begin
            check({tag, "/hs_idle"}, 32'({ready, busy, done}), 32'(3'b100));
            check({tag, "/held_result"}, 32'(result), 32'(prev_result));
            check({tag, "/held_carry"}, 32'(carry), 32'(prev_carry));
         end
         start = (c == start_cycle) && (c < last);
         abort = (c == abort_cycle) && (c < last);
         if (start) begin
            op      = 2'($urandom);
            operand = 4'($urandom);
            amount  = 4'($urandom_range(1, 15));
         end
         if (c < last) tick();
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      op          = 2'b00;
      operand     = 4'h0;
      amount      = 4'h0;
      prev_result = 4'h0;
      prev_carry  = 1'b0;
      tick();
      tick();
      check("reset/hs", 32'({ready, busy, done}), 32'(3'b100));
      check("reset/result", 32'(result), 32'h0);
      check("reset/carry", 32'(carry), 32'h0);
      rst = 1'b0;
      tick();

      $display("[TB] directed scenarios");
      apply_stimulus(OP_ROL, 4'b1011, 4'd5);
      check_output(OP_ROL, 4'b1011, 4'd5, 0, 0, "rol5");
      check("rol5/lit_result", 32'(result), 32'(4'b0111));
      check("rol5/lit_carry", 32'(carry), 32'(CARRY_ON));

      apply_stimulus(OP_SHL, 4'b1011, 4'd7);
      check_output(OP_SHL, 4'b1011, 4'd7, 0, 2, "shl7");
      check("shl7/lit_result", 32'(result), 32'(4'b0000));

      apply_stimulus(OP_SHR, 4'b1001, 4'd1);
      check_output(OP_SHR, 4'b1001, 4'd1, 0, 0, "shr1");
      check("shr1/lit_result", 32'(result), 32'(4'b0100));
      check("shr1/lit_carry", 32'(carry), 32'(CARRY_ON));

      apply_stimulus(OP_ROR, 4'b0001, 4'd0);
      check_output(OP_ROR, 4'b0001, 4'd0, 0, 0, "ror0");
      check("ror0/lit_result", 32'(result), 32'(4'b0001));

      apply_stimulus(OP_SHL, 4'b0110, 4'd15);
      check_output(OP_SHL, 4'b0110, 4'd15, 2, 0, "shl15_abort");
      check("shl15_abort/lit_result", 32'(result), 32'(4'b0001));

      op      = OP_SHL;
      operand = 4'hF;
      amount  = 4'd5;
      start   = 1'b1;
      abort   = 1'b1;
      tick();
      start   = 1'b0;
      abort   = 1'b0;
      check("start_abort/hs0", 32'({ready, busy, done}), 32'(3'b100));
      tick();
      check("start_abort/hs1", 32'({ready, busy, done}), 32'(3'b100));
      check("start_abort/result", 32'(result), 32'(4'b0001));

      apply_stimulus(OP_SHL, 4'b0111, 4'd15);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midreset/hs", 32'({ready, busy, done}), 32'(3'b100));
      check("midreset/result", 32'(result), 32'h0);
      check("midreset/carry", 32'(carry), 32'h0);
      prev_result = 4'h0;
      prev_carry  = 1'b0;
      tick();
      check("midreset/stays_idle", 32'({ready, busy, done}), 32'(3'b100));

      $display("[TB] random operations");
      for (int i = 0; i < 60; i++) begin
         logic [1:0] ro = 2'($urandom);
         logic [3:0] rd = 4'($urandom);
         logic [3:0] ra = 4'($urandom);
         int lat = 1 + (int'(ra) + 2) / 3;
         int ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : 0;
         int sc  = 0;
         bit was_aborted = (ab >= 1) && (ab < lat);
         if ($urandom_range(0, 2) == 0)
            sc = int'($urandom_range(1, was_aborted ? ab : lat));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         apply_stimulus(ro, rd, ra);
         check_output(ro, rd, ra, ab, sc, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
